// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared types and constants for the instruction-fetch stage.
//   u32_t        : 32-bit machine word
//   id_params_t  : fetch -> decode payload {ia_plus_4, ir}
//   FETCH_FIFO_DEPTH, RESET_VECTOR_DEFAULT, word_align()
package fetch_stage_pkg;

    typedef logic [31:0] u32_t;

    typedef struct packed {
        u32_t ia_plus_4;
        u32_t ir;
    } id_params_t;

    localparam int   FETCH_FIFO_DEPTH     = 2;
    localparam u32_t RESET_VECTOR_DEFAULT = 32'h0000_0000;

    function automatic u32_t word_align(input u32_t a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory request/grant/response bus.
//   imem_req_o/imem_addr_o : fetch -> memory read request
//   imem_gnt_i             : memory accepts the request this cycle
//   imem_rvalid_i/rdata_i  : in-order read response
// master = fetch stage, slave = instruction memory.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic imem_req_o;
    u32_t imem_addr_o;
    logic imem_gnt_i;
    logic imem_rvalid_i;
    u32_t imem_rdata_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i
    );
endinterface

// File: rtl/fetch_stage_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO of id_params_t.
//   push/din  : write an entry (ignored when full unless popping too)
//   pop/dout  : head entry, read straight from storage (registered)
//   flush     : empty the FIFO, has priority over push/pop
//   full/empty/count : occupancy
module fetch_fifo
    import fetch_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       push,
    input  id_params_t din,
    input  logic       pop,
    output id_params_t dout,
    output logic       full,
    output logic       empty,
    output logic [1:0] count
);
    id_params_t mem_q [FETCH_FIFO_DEPTH];
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign full  = (count_q == 2'd2);
    assign empty = (count_q == 2'd0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FETCH_FIFO_DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !flush && full && !pop));

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch, upstream of decode.
//   clk, rst_n          : clock, async active-low reset
//   imem (master)       : instruction-memory request/grant/response bus
//   redirect_i/addr_i   : flush and restart fetch at a new PC
//   id_valid_o/params_o : {pc+4, instruction} to decode, id_ready_i accepts
// Build option: FETCH_DUAL_OUTSTANDING_EN allows two reads in flight;
// without it one read is in flight and the address queue is one register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter u32_t RESET_VECTOR = RESET_VECTOR_DEFAULT
)(
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        imem,
    input  logic                 redirect_i,
    input  u32_t                 redirect_addr_i,
    output logic                 id_valid_o,
    output id_params_t           id_params_o,
    input  logic                 id_ready_i
);
`ifdef FETCH_DUAL_OUTSTANDING_EN
    localparam logic [1:0] MAX_OUT = 2'd2;
`else
    localparam logic [1:0] MAX_OUT = 2'd1;
`endif

    u32_t       pc_q;
    logic [1:0] out_cnt_q;
    logic [1:0] squash_cnt_q;
    logic       active_q;
    logic [1:0] out_cnt_next;
    logic [1:0] fifo_count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       grant;
    logic       rsp_pop;
    logic       rsp_keep;
    u32_t       aq_head;
    id_params_t fifo_din;

    // Credit counts squashed reads and buffered words alike, so the FIFO can
    // never be overrun. active_q keeps the request low while in reset without
    // a combinational path from rst_n.
    assign imem.imem_req_o  = active_q && (out_cnt_q < MAX_OUT) &&
                              (({1'b0, out_cnt_q} + {1'b0, fifo_count}) < 3'd2);
    assign imem.imem_addr_o = pc_q;

    assign grant        = imem.imem_req_o && imem.imem_gnt_i;
    assign rsp_pop      = imem.imem_rvalid_i && (out_cnt_q != 2'd0);
    assign rsp_keep     = rsp_pop && (squash_cnt_q == 2'd0) && !redirect_i;
    assign out_cnt_next = out_cnt_q + {1'b0, grant} - {1'b0, rsp_pop};
    assign fifo_din     = '{ia_plus_4: aq_head + 32'd4, ir: imem.imem_rdata_i};
    assign id_valid_o   = !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= word_align(RESET_VECTOR);
            out_cnt_q    <= 2'd0;
            squash_cnt_q <= 2'd0;
            active_q     <= 1'b0;
        end else begin
            active_q  <= 1'b1;
            out_cnt_q <= out_cnt_next;
            if (redirect_i) begin
                pc_q         <= word_align(redirect_addr_i);
                squash_cnt_q <= out_cnt_next;
            end else begin
                if (grant) pc_q <= pc_q + 32'd4;
                if (rsp_pop && squash_cnt_q != 2'd0) squash_cnt_q <= squash_cnt_q - 2'd1;
            end
        end
    end

    // Addresses of granted reads, in request order; squashed reads still pass
    // through so the head always matches the next response.
`ifdef FETCH_DUAL_OUTSTANDING_EN
    u32_t aq_q [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aq_q[0] <= '0;
            aq_q[1] <= '0;
        end else begin
            if (rsp_pop) aq_q[0] <= aq_q[1];
            if (grant) begin
                if (out_cnt_q == 2'd0 || (out_cnt_q == 2'd1 && rsp_pop)) aq_q[0] <= pc_q;
                else aq_q[1] <= pc_q;
            end
        end
    end

    assign aq_head = aq_q[0];
`else
    u32_t aq_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) aq_q <= '0;
        else if (grant) aq_q <= pc_q;
    end

    assign aq_head = aq_q;
`endif

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_i),
        .push  (rsp_keep),
        .din   (fifo_din),
        .pop   (id_valid_o && id_ready_i),
        .dout  (id_params_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    a_no_req_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        fifo_full |-> !imem.imem_req_o);

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;
    import fetch_stage_pkg::*;

`ifdef FETCH_DUAL_OUTSTANDING_EN
    localparam int MAX_OUT = 2;
`else
    localparam int MAX_OUT = 1;
`endif
    localparam u32_t RV = 32'h0000_0000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       redirect_i = 1'b0;
    u32_t       redirect_addr_i = '0;
    logic       id_valid_o;
    id_params_t id_params_o;
    logic       id_ready_i = 1'b0;

    fetch_stage_if bus();

    fetch_stage #(.RESET_VECTOR(RV)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem            (bus),
        .redirect_i      (redirect_i),
        .redirect_addr_i (redirect_addr_i),
        .id_valid_o      (id_valid_o),
        .id_params_o     (id_params_o),
        .id_ready_i      (id_ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Memory model: pending reads with due cycle and the redirect epoch they
    // were granted in. Reference model: granted-but-unconsumed addresses of
    // the current epoch, count of words sitting in the output buffer, next PC.
    typedef struct {
        u32_t addr;
        int   due;
        int   tag;
    } pend_t;
    pend_t pend_q[$];
    u32_t  exp_q[$];
    int    buf_n = 0;
    int    epoch = 0;
    u32_t  m_pc = RV;
    int    delivered = 0;
    int    lat_min = 1;
    int    lat_max = 1;
    int    gnt_pct = 100;

    logic       obs_req;
    u32_t       obs_addr;
    logic       obs_valid;
    id_params_t obs_params;

    function automatic u32_t mem_word(input u32_t a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // redir_mode: 0 none, 1 always, 2 when a response lands (and a grant, if
    // two reads can be in flight), 3 random
    task automatic step(input bit rdy, input int redir_mode, input u32_t raddr, output bit did_redir);
        bit         gnt;
        bit         rv;
        bit         redir;
        bit         exp_req;
        u32_t       rdata;
        id_params_t exp_p;
        pend_t      p;
        @(negedge clk);
        obs_req    = bus.imem_req_o;
        obs_addr   = bus.imem_addr_o;
        obs_valid  = id_valid_o;
        obs_params = id_params_o;
        exp_req = (pend_q.size() < MAX_OUT) && (pend_q.size() + buf_n < 2);
        checks++;
        if (obs_req !== exp_req) begin
            failures++;
            $display("FAIL req_issue cyc=%0d actual=%0b required=%0b", cyc, obs_req, exp_req);
        end
        if (obs_req) begin
            checks++;
            if (obs_addr !== m_pc) begin
                failures++;
                $display("FAIL req_addr cyc=%0d actual=%h required=%h", cyc, obs_addr, m_pc);
            end
        end
        checks++;
        if (obs_valid !== (buf_n > 0)) begin
            failures++;
            $display("FAIL id_valid cyc=%0d actual=%0b required=%0b", cyc, obs_valid, buf_n > 0);
        end
        if (buf_n > 0) begin
            exp_p = '{ia_plus_4: exp_q[0] + 32'd4, ir: mem_word(exp_q[0])};
            checks++;
            if (obs_params !== exp_p) begin
                failures++;
                $display("FAIL id_params cyc=%0d actual=%h required=%h", cyc, obs_params, exp_p);
            end
        end

        gnt   = ($urandom_range(99) < gnt_pct);
        rv    = (pend_q.size() > 0) && (pend_q[0].due <= cyc);
        rdata = rv ? mem_word(pend_q[0].addr) : $urandom;
        case (redir_mode)
            1:       redir = 1'b1;
            2:       redir = rv && (MAX_OUT == 1 || (obs_req && gnt));
            3:       redir = ($urandom_range(99) < 4);
            default: redir = 1'b0;
        endcase
        bus.imem_gnt_i    = gnt;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rdata;
        redirect_i        = redir;
        redirect_addr_i   = raddr;
        id_ready_i        = rdy;

        if (!redir && buf_n > 0 && rdy) begin
            void'(exp_q.pop_front());
            buf_n--;
            delivered++;
        end
        if (rv) begin
            p = pend_q.pop_front();
            if (p.tag == epoch && !redir) buf_n++;
        end
        if (obs_req && gnt) begin
            pend_q.push_back('{addr: obs_addr, due: cyc + int'($urandom_range(lat_max, lat_min)), tag: epoch});
            if (!redir) exp_q.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            epoch++;
            exp_q.delete();
            buf_n = 0;
            m_pc  = raddr & 32'hFFFF_FFFC;
        end
        did_redir = redir;
        cyc++;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.imem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_req actual=%0b required=0", bus.imem_req_o);
        end
        checks++;
        if (id_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid actual=%0b required=0", id_valid_o);
        end
        checks++;
        if (id_params_o !== '0) begin
            failures++;
            $display("FAIL reset_params actual=%h required=0", id_params_o);
        end
        checks++;
        if (bus.imem_addr_o !== RV) begin
            failures++;
            $display("FAIL reset_addr actual=%h required=%h", bus.imem_addr_o, RV);
        end
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        redirect_i        = 1'b0;
        id_ready_i        = 1'b0;
        pend_q.delete();
        exp_q.delete();
        buf_n = 0;
        epoch++;
        m_pc = RV;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.imem_req_o !== 1'b0) begin
            failures++;
            $display("FAIL release_req actual=%0b required=0", bus.imem_req_o);
        end
    endtask

    task automatic test_reset();
        bit r;
        apply_reset();
        step(1'b1, 0, '0, r);
        checks++;
        if (obs_req !== 1'b1 || obs_addr !== RV) begin
            failures++;
            $display("FAIL first_req actual=%0b/%h required=1/%h", obs_req, obs_addr, RV);
        end
    endtask

    task automatic test_stream();
        bit r;
        int d0;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        d0 = delivered;
        repeat (12) step(1'b1, 0, '0, r);
        checks++;
        if (delivered - d0 < 5) begin
            failures++;
            $display("FAIL stream_rate actual=%0d required>=5", delivered - d0);
        end
    endtask

    task automatic test_stall();
        bit r;
        lat_min = 1; lat_max = 2; gnt_pct = 100;
        repeat (10) step(1'b0, 0, '0, r);
        step(1'b0, 0, '0, r);
        checks++;
        if (obs_valid !== 1'b1 || obs_req !== 1'b0) begin
            failures++;
            $display("FAIL stall_full actual=valid%0b/req%0b required=valid1/req0", obs_valid, obs_req);
        end
        repeat (10) step(1'b1, 0, '0, r);
    endtask

    task automatic test_redirect_inflight();
        bit r;
        bit seen;
        lat_min = 3; lat_max = 3; gnt_pct = 100;
        for (int i = 0; i < 20 && pend_q.size() < MAX_OUT; i++) step(1'b1, 0, '0, r);
        checks++;
        if (pend_q.size() != MAX_OUT) begin
            failures++;
            $display("FAIL inflight_setup actual=%0d required=%0d", pend_q.size(), MAX_OUT);
        end
        step(1'b1, 1, 32'h0000_1003, r);
        lat_min = 1; lat_max = 1;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1'b1, 0, '0, r);
            if (obs_req && pend_q.size() > 0 && pend_q[$].tag == epoch && !seen && pend_q[$].addr == obs_addr) begin
                if (pend_q.size() == 1 || pend_q[0].tag != epoch) begin
                    checks++;
                    if (obs_addr !== 32'h0000_1000) begin
                        failures++;
                        $display("FAIL redirect_addr actual=%h required=00001000", obs_addr);
                    end
                    seen = 1'b1;
                end
            end
        end
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1'b1, 0, '0, r);
            if (obs_valid) begin
                seen = 1'b1;
                checks++;
                if (obs_params.ia_plus_4 !== 32'h0000_1004) begin
                    failures++;
                    $display("FAIL redirect_first_out actual=%h required=00001004", obs_params.ia_plus_4);
                end
            end
        end
        if (!seen) begin
            failures++;
            $display("FAIL redirect_timeout no output within 30 cycles");
        end
    endtask

    task automatic test_redirect_collide();
        bit r;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        r = 1'b0;
        for (int i = 0; i < 40 && !r; i++) step(1'b1, 2, 32'h0000_2000, r);
        checks++;
        if (!r) begin
            failures++;
            $display("FAIL collide_timeout actual=none required=redirect");
        end
        step(1'b1, 0, '0, r);
        checks++;
        if (obs_valid !== 1'b0) begin
            failures++;
            $display("FAIL collide_valid actual=%0b required=0", obs_valid);
        end
        repeat (8) step(1'b1, 0, '0, r);
    endtask

    task automatic test_wrap();
        bit r;
        bit seen;
        lat_min = 1; lat_max = 2; gnt_pct = 100;
        step(1'b1, 1, 32'hFFFF_FFFC, r);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(1'b1, 0, '0, r);
            if (obs_valid) begin
                seen = 1'b1;
                checks++;
                if (obs_params.ia_plus_4 !== 32'h0 || obs_params.ir !== mem_word(32'hFFFF_FFFC)) begin
                    failures++;
                    $display("FAIL wrap_out actual=%h required=%h", obs_params,
                             {32'h0, mem_word(32'hFFFF_FFFC)});
                end
            end
        end
        if (!seen) begin
            failures++;
            $display("FAIL wrap_timeout no output within 30 cycles");
        end
        repeat (6) step(1'b1, 0, '0, r);
    endtask

    task automatic test_random();
        bit r;
        lat_min = 1; lat_max = 4; gnt_pct = 70;
        for (int i = 0; i < 400; i++)
            step(($urandom_range(99) < 60), 3, $urandom, r);
    endtask

    task automatic test_reset_midstall();
        bit r;
        bit seen;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        repeat (8) step(1'b0, 0, '0, r);
        step(1'b0, 0, '0, r);
        checks++;
        if (obs_valid !== 1'b1) begin
            failures++;
            $display("FAIL midstall_valid actual=%0b required=1", obs_valid);
        end
        apply_reset();
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            step(1'b1, 0, '0, r);
            if (obs_req) begin
                seen = 1'b1;
                checks++;
                if (obs_addr !== RV) begin
                    failures++;
                    $display("FAIL restart_addr actual=%h required=%h", obs_addr, RV);
                end
            end
        end
        if (!seen) begin
            failures++;
            $display("FAIL restart_timeout no request within 5 cycles");
        end
        repeat (10) step(1'b1, 0, '0, r);
    endtask

    initial begin
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_inflight();
        test_redirect_collide();
        test_wrap();
        test_random();
        test_reset_midstall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
